// File: rtl/tia_biphase_d1r_if.sv
// tia_biphase_d1r_if - signal bundle for the TIA biphase generator / D1R stage.
// Optional build macro: TIA_D1R_OUTN_EN adds the inverted data output out_n.
`timescale 1ns/1ps

interface tia_biphase_d1r_if;
  logic rsyn;
  logic in;
  logic hphi1;
  logic hphi2;
  logic rsynl;
  logic out;
`ifdef TIA_D1R_OUTN_EN
  logic out_n;

  modport slave  (input  rsyn, in, output hphi1, hphi2, rsynl, out, out_n);
  modport master (output rsyn, in, input  hphi1, hphi2, rsynl, out, out_n);
`else
  modport slave  (input  rsyn, in, output hphi1, hphi2, rsynl, out);
  modport master (output rsyn, in, input  hphi1, hphi2, rsynl, out);
`endif
endinterface

// File: rtl/tia_biphase_d1r.sv
// tia_biphase_d1r - TIA biphase clock generator (colour clock / 4, two
// non-overlapping phases) driving a D1R resettable two-phase delay stage.
// Optional build macro: TIA_D1R_OUTN_EN exposes out_n = ~out.
`timescale 1ns/1ps

module tia_biphase_d1r (
  input  logic             clk,
  input  logic             r,
  tia_biphase_d1r_if.slave bus
);

  // Gray-coded divider: only one bit flips per step, so the phase decodes
  // below cannot glitch.
  typedef enum logic [1:0] {
    PH1  = 2'b00,
    GAP1 = 2'b01,
    PH2  = 2'b11,
    GAP2 = 2'b10
  } phase_e;

  // NOTE: the divider and rsynl have no reset input at all; r only resets the
  // D1R stage, so their power-up value comes from the declaration initializer.
  phase_e g = PH1;
  phase_e g_next;
  logic   rsynl_q = 1'b0;

  logic   m;
  logic   out_q;
  logic   armed;   // set once a complete phi1 can follow a reset release

  // Divider state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    g <= g_next;
  end

  // Next-state: advance the Gray sequence; rsyn forces the phi1 state.
  // NOTE: g_next gets a default first so no path leaves it unassigned, which
  // would otherwise infer a latch.
  always_comb begin
    g_next = g;
    if (bus.rsyn) begin
      g_next = PH1;
    end else begin
      unique case (g)
        PH1:     g_next = GAP1;
        GAP1:    g_next = PH2;
        PH2:     g_next = GAP2;
        GAP2:    g_next = PH1;
        default: g_next = PH1;
      endcase
    end
  end

  // Phase outputs decoded directly from the Gray state.
  always_comb begin
    bus.hphi1 = 1'b0;
    bus.hphi2 = 1'b0;
    if (g == PH1) bus.hphi1 = 1'b1;
    if (g == PH2) bus.hphi2 = 1'b1;
  end

  // Registered copy of rsyn, free of the D1R reset.
  always_ff @(posedge clk) begin
    rsynl_q <= bus.rsyn;
  end

  // D1R stage: master captures at the phi1 exit edge, slave loads at the
  // phi2 entry edge. A phi1 only counts if the edge that entered it was seen
  // out of reset, so a release inside phi1 leaves m at 0 for that cycle.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      m     <= 1'b0;
      out_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      if (g != PH1) armed <= 1'b1;
      if (g == PH1 && armed) m <= bus.in;
      if (g == GAP1 && g_next == PH2) out_q <= m;
    end
  end

  assign bus.rsynl = rsynl_q;
  assign bus.out   = out_q;
`ifdef TIA_D1R_OUTN_EN
  assign bus.out_n = ~out_q;
`endif

endmodule

// File: tb/tb_tia_biphase_d1r.sv
// tb_tia_biphase_d1r - directed self-checking bench for tia_biphase_d1r.
// Build with TIA_D1R_OUTN_EN defined to also check out_n.
`timescale 1ns/1ps

module tb_tia_biphase_d1r;

  logic clk;
  logic r;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ph       = 0;     // expected divider position: 0=phi1, 2=phi2
  logic exp_rsynl = 1'b0;

  tia_biphase_d1r_if bus ();

  tia_biphase_d1r dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input logic exp);
    check("out", bus.out, exp);
`ifdef TIA_D1R_OUTN_EN
    check("out_n", bus.out_n, ~exp);
`endif
  endtask

  // One colour clock: predict the divider and rsynl, then compare 1 ns later.
  task automatic tick();
    exp_rsynl = bus.rsyn;
    ph = bus.rsyn ? 0 : (ph + 1) % 4;
    @(posedge clk);
    #1;
    check("hphi1", bus.hphi1, ph == 0);
    check("hphi2", bus.hphi2, ph == 2);
    check("rsynl", bus.rsynl, exp_rsynl);
  endtask

  // One biphase cycle starting just after hphi1 rises: drive in, check out
  // right after the following hphi2 rise, finish at the next hphi1.
  task automatic cyc(input logic v, input logic exp);
    bus.in = v;
    tick();
    tick();
    check_out(exp);
    tick();
    tick();
  endtask

  initial begin
    r        = 1'b0;
    bus.rsyn = 1'b0;
    bus.in   = 1'b0;
    #1 r = 1'b1;
    #1;
    // Reset state
    check("rst_hphi1", bus.hphi1, 1'b1);
    check("rst_hphi2", bus.hphi2, 1'b0);
    check("rst_rsynl", bus.rsynl, 1'b0);
    check_out(1'b0);
    r = 1'b0;

    // Free run, 16 clocks
    for (int i = 0; i < 16; i++) tick();

    // D1R sequence, biphase cycles 1-6
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    // Reset hold, cycles 7-16
    r = 1'b1;
    #1;
    check_out(1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);

    // Release inside phi1: that cycle's capture is lost
    r = 1'b0;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);

    // Asynchronous reset between clock edges while out=1
    bus.in = 1'b1;
    tick();
    tick();
    check_out(1'b1);
    #3 r = 1'b1;
    #1;
    check_out(1'b0);
    #1 r = 1'b0;
    tick();
    tick();
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);

    // Single-clock resync while g=11
    tick();
    tick();
    bus.rsyn = 1'b1;
    tick();
    bus.rsyn = 1'b0;
    for (int i = 0; i < 7; i++) tick();

    // Held resync: phi1 pinned, phi2 silent, rsynl stays 1
    bus.rsyn = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    bus.rsyn = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
